laser_target_loader: RTL and testbench

- Upstream input stage for the laser-treatment circle solver.
- Accepts the 40 target points (X,Y on a 16x16 grid) over a valid/ready stream and stores them in a register buffer.
- Serves the points 4 per cycle by group index, which matches the solver's 4-lane hit evaluation.
- Tracks the points' bounding box so the solver can narrow its centre search; holds the buffer until the solver releases it, then refills.

---
 rtl/laser_pkg.sv | 41 ++++
 rtl/laser_bbox_tracker.sv | 30 +++
 rtl/laser_target_loader.sv | 127 ++++++++++++
 tb/tb_laser_target_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// Shared types and constants for the laser-treatment target loader and solver.
// Points are packed {x,y}; the bounding-box helpers are shared with the solver debug logic.
package laser_pkg;

   localparam int COORD_W = 4;
   localparam int NUM_PTS = 40;
   localparam int LANES   = 4;
   localparam int NUM_GRP = NUM_PTS / LANES;
   localparam int CNT_W   = 6;
   localparam int GRP_W   = 4;

   localparam logic [COORD_W-1:0] BOX_MIN_INIT = '1;
   localparam logic [COORD_W-1:0] BOX_MAX_INIT = '0;

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_FULL = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } point_t;

   function automatic logic [COORD_W-1:0] coord_min(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [COORD_W-1:0] coord_max(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // First buffer index of a read group; 6 bits wide so groups up to 15 never wrap.
   function automatic logic [CNT_W-1:0] grp_offset(input logic [GRP_W-1:0] grp);
      return CNT_W'(grp) * CNT_W'(LANES);
   endfunction

endpackage

// File: rtl/laser_bbox_tracker.sv
// Running min/max of X and Y over accepted points; clear has priority over update.
module laser_bbox_tracker
   import laser_pkg::*;
(
   input  logic               CLK,
   input  logic               RST,
   input  logic               clr,
   input  logic               upd,
   input  point_t             pt,
   output logic [COORD_W-1:0] min_x,
   output logic [COORD_W-1:0] max_x,
   output logic [COORD_W-1:0] min_y,
   output logic [COORD_W-1:0] max_y
);

   always_ff @(posedge CLK) begin
      if (RST || clr) begin
         min_x <= BOX_MIN_INIT;
         max_x <= BOX_MAX_INIT;
         min_y <= BOX_MIN_INIT;
         max_y <= BOX_MAX_INIT;
      end else if (upd) begin
         min_x <= coord_min(min_x, pt.x);
         max_x <= coord_max(max_x, pt.x);
         min_y <= coord_min(min_y, pt.y);
         max_y <= coord_max(max_y, pt.y);
      end
   end

endmodule

// File: rtl/laser_target_loader.sv
// Input stage for the circle solver: buffers one frame of target points, serves them
// four per cycle by group, and tracks their bounding box until the solver releases the frame.
//
// state  | meaning
// S_FILL | accepting points into the buffer, one per cycle
// S_FULL | frame just completed, LOAD_DONE pulses
// S_HOLD | buffer and box frozen for the solver until SOLVER_DONE
module laser_target_loader
   import laser_pkg::*;
(
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     IN_VALID,
   output logic                     IN_READY,
   input  logic [COORD_W-1:0]       IN_X,
   input  logic [COORD_W-1:0]       IN_Y,
   output logic                     LOAD_DONE,
   output logic                     BUF_FULL,
   output logic [CNT_W-1:0]         PT_COUNT,
   input  logic [GRP_W-1:0]         RD_GRP,
   output logic [LANES*COORD_W-1:0] RD_X,
   output logic [LANES*COORD_W-1:0] RD_Y,
   output logic [COORD_W-1:0]       MIN_X,
   output logic [COORD_W-1:0]       MAX_X,
   output logic [COORD_W-1:0]       MIN_Y,
   output logic [COORD_W-1:0]       MAX_Y,
   input  logic                     SOLVER_DONE
);

   state_t                   state;
   point_t                   pt_buf [NUM_PTS];
   point_t                   in_pt;
   logic                     accept;
   logic                     release_buf;
   logic [CNT_W-1:0]         grp_base;
   logic [CNT_W-1:0]         lane_idx;
   point_t                   lane_pt;
   logic [LANES*COORD_W-1:0] rd_x_nxt;
   logic [LANES*COORD_W-1:0] rd_y_nxt;

   assign in_pt       = {IN_X, IN_Y};
   assign IN_READY    = (state == S_FILL) && !RST;
   assign accept      = IN_VALID && IN_READY;
   assign release_buf = (state == S_HOLD) && SOLVER_DONE;
   assign grp_base    = grp_offset(RD_GRP);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_FILL;
         PT_COUNT  <= '0;
         LOAD_DONE <= 1'b0;
         BUF_FULL  <= 1'b0;
      end else begin
         LOAD_DONE <= 1'b0;
         case (state)
            S_FILL: begin
               if (accept) begin
                  PT_COUNT <= PT_COUNT + CNT_W'(1);
                  if (PT_COUNT == CNT_W'(NUM_PTS - 1)) begin
                     state     <= S_FULL;
                     LOAD_DONE <= 1'b1;
                     BUF_FULL  <= 1'b1;
                  end
               end
            end
            S_FULL: state <= S_HOLD;
            S_HOLD: begin
               if (SOLVER_DONE) begin
                  state    <= S_FILL;
                  PT_COUNT <= '0;
                  BUF_FULL <= 1'b0;
               end
            end
            default: state <= S_FILL;
         endcase
      end
   end

   // Buffer storage is deliberately not reset; PT_COUNT alone defines which entries are live.
   always_ff @(posedge CLK) begin
      if (accept) begin
         pt_buf[PT_COUNT] <= in_pt;
      end
   end

   // Write-first read: a lane that hits the entry being written this cycle sees the new point.
   always_comb begin
      rd_x_nxt = '0;
      rd_y_nxt = '0;
      lane_idx = '0;
      lane_pt  = '0;
      if (RD_GRP < GRP_W'(NUM_GRP)) begin
         for (int k = 0; k < LANES; k++) begin
            lane_idx = grp_base + CNT_W'(k);
            lane_pt  = pt_buf[lane_idx];
            if (accept && (PT_COUNT == lane_idx)) begin
               lane_pt = in_pt;
            end
            rd_x_nxt[k*COORD_W +: COORD_W] = lane_pt.x;
            rd_y_nxt[k*COORD_W +: COORD_W] = lane_pt.y;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         RD_X <= '0;
         RD_Y <= '0;
      end else begin
         RD_X <= rd_x_nxt;
         RD_Y <= rd_y_nxt;
      end
   end

   laser_bbox_tracker u_bbox (
      .CLK   (CLK),
      .RST   (RST),
      .clr   (release_buf),
      .upd   (accept),
      .pt    (in_pt),
      .min_x (MIN_X),
      .max_x (MAX_X),
      .min_y (MIN_Y),
      .max_y (MAX_Y)
   );

endmodule

// File: tb/tb_laser_target_loader.sv
// Randomized bench for laser_target_loader against a frame-level reference model.
module tb_laser_target_loader;

   localparam int NPTS = 40;
   localparam int NGRP = 10;

   logic        CLK = 1'b0;
   logic        RST;
   logic        IN_VALID;
   logic        IN_READY;
   logic [3:0]  IN_X;
   logic [3:0]  IN_Y;
   logic        LOAD_DONE;
   logic        BUF_FULL;
   logic [5:0]  PT_COUNT;
   logic [3:0]  RD_GRP;
   logic [15:0] RD_X;
   logic [15:0] RD_Y;
   logic [3:0]  MIN_X;
   logic [3:0]  MAX_X;
   logic [3:0]  MIN_Y;
   logic [3:0]  MAX_Y;
   logic        SOLVER_DONE;

   laser_target_loader dut (
      .CLK         (CLK),
      .RST         (RST),
      .IN_VALID    (IN_VALID),
      .IN_READY    (IN_READY),
      .IN_X        (IN_X),
      .IN_Y        (IN_Y),
      .LOAD_DONE   (LOAD_DONE),
      .BUF_FULL    (BUF_FULL),
      .PT_COUNT    (PT_COUNT),
      .RD_GRP      (RD_GRP),
      .RD_X        (RD_X),
      .RD_Y        (RD_Y),
      .MIN_X       (MIN_X),
      .MAX_X       (MAX_X),
      .MIN_Y       (MIN_Y),
      .MAX_Y       (MAX_Y),
      .SOLVER_DONE (SOLVER_DONE)
   );

   always #5 CLK = ~CLK;

   int         n_chk = 0;
   int         n_pass = 0;
   int         ld_cnt = 0;
   int         mdl_cnt = 0;
   logic [3:0] mdl_x [NPTS];
   logic [3:0] mdl_y [NPTS];
   int         lx [4] = '{3, 9, 12, 5};
   int         ly [3] = '{1, 14, 7};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
      if (LOAD_DONE === 1'b1) ld_cnt++;
   endtask

   task automatic gen_pt(input int mode, input int i, output logic [3:0] px, output logic [3:0] py);
      case (mode)
         0:       begin px = 4'(i % 16);  py = 4'((i + 5) % 16); end
         1:       begin px = 4'(lx[i % 4]); py = 4'(ly[i % 3]); end
         3:       begin px = 4'd15; py = 4'd0; end
         4:       begin px = 4'd0;  py = 4'd15; end
         default: begin px = 4'($urandom_range(0, 15)); py = 4'($urandom_range(0, 15)); end
      endcase
   endtask

   function automatic logic [15:0] exp_rd(input int g, input bit sel_y);
      logic [15:0] r = '0;
      if (g < NGRP) begin
         for (int k = 0; k < 4; k++)
            r[4*k +: 4] = sel_y ? mdl_y[4*g + k] : mdl_x[4*g + k];
      end
      return r;
   endfunction

   task automatic chk_box(input string tag);
      logic [3:0] mnx = 4'd15, mxx = 4'd0, mny = 4'd15, mxy = 4'd0;
      for (int i = 0; i < mdl_cnt; i++) begin
         if (mdl_x[i] < mnx) mnx = mdl_x[i];
         if (mdl_x[i] > mxx) mxx = mdl_x[i];
         if (mdl_y[i] < mny) mny = mdl_y[i];
         if (mdl_y[i] > mxy) mxy = mdl_y[i];
      end
      chk({tag, "_min_x"}, MIN_X, mnx);
      chk({tag, "_max_x"}, MAX_X, mxx);
      chk({tag, "_min_y"}, MIN_Y, mny);
      chk({tag, "_max_y"}, MAX_Y, mxy);
   endtask

   // vmode: 0 continuous valid, 1 valid every other cycle, 2 random valid
   task automatic fill(input int n, input int mode, input int vmode);
      int         cyc = 0;
      logic [3:0] px, py;
      logic       v, will;
      while (mdl_cnt < n && cyc < 400) begin
         gen_pt(mode, mdl_cnt, px, py);
         case (vmode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         IN_VALID    = v;
         IN_X        = px;
         IN_Y        = py;
         RD_GRP      = (mdl_cnt == NPTS - 1) ? 4'd9 : 4'd15;
         SOLVER_DONE = 1'($urandom_range(0, 1));
         will        = v && IN_READY;
         step();
         if (will) begin
            mdl_x[mdl_cnt] = px;
            mdl_y[mdl_cnt] = py;
            mdl_cnt++;
            chk("fill_pt_count", PT_COUNT, mdl_cnt);
         end
         cyc++;
      end
      IN_VALID    = 1'b0;
      SOLVER_DONE = 1'b0;
      if (mdl_cnt < n) chk("fill_timeout", mdl_cnt, n);
      if (vmode == 1) chk("fill_alt_cycles", cyc, 2 * n - 1);
   endtask

   task automatic check_full();
      chk("full_load_done", LOAD_DONE, 1'b1);
      chk("full_buf_full", BUF_FULL, 1'b1);
      chk("full_in_ready", IN_READY, 1'b0);
      chk("full_pt_count", PT_COUNT, NPTS);
      chk("wr_first_rd_x", RD_X, exp_rd(9, 1'b0));
      chk("wr_first_rd_y", RD_Y, exp_rd(9, 1'b1));
      chk_box("full");
      SOLVER_DONE = 1'b1;
      IN_VALID    = 1'b1;
      step();
      SOLVER_DONE = 1'b0;
      chk("hold_load_done_low", LOAD_DONE, 1'b0);
      chk("hold_buf_full", BUF_FULL, 1'b1);
      chk("hold_in_ready", IN_READY, 1'b0);
      step();
      IN_VALID = 1'b0;
      step();
      chk("load_done_pulses", ld_cnt, 1);
      chk("hold_pt_count", PT_COUNT, NPTS);
      chk_box("hold");
   endtask

   task automatic sweep();
      int gl [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 15, 0, 0, 0, 0};
      for (int i = 12; i < 16; i++) gl[i] = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) begin
         RD_GRP = 4'(gl[i]);
         step();
         chk($sformatf("rd_x_g%0d", gl[i]), RD_X, exp_rd(gl[i], 1'b0));
         chk($sformatf("rd_y_g%0d", gl[i]), RD_Y, exp_rd(gl[i], 1'b1));
      end
   endtask

   task automatic hold_test();
      for (int i = 0; i < 20; i++) begin
         IN_VALID = 1'b1;
         IN_X     = 4'($urandom_range(0, 15));
         IN_Y     = 4'($urandom_range(0, 15));
         step();
      end
      IN_VALID = 1'b0;
      chk("stall_pt_count", PT_COUNT, NPTS);
      chk("stall_buf_full", BUF_FULL, 1'b1);
      chk("stall_in_ready", IN_READY, 1'b0);
      chk_box("stall");
      sweep();
   endtask

   task automatic release_frame();
      SOLVER_DONE = 1'b1;
      IN_VALID    = 1'b1;
      IN_X        = 4'($urandom_range(0, 15));
      IN_Y        = 4'($urandom_range(0, 15));
      step();
      SOLVER_DONE = 1'b0;
      IN_VALID    = 1'b0;
      mdl_cnt     = 0;
      chk("rel_in_ready", IN_READY, 1'b1);
      chk("rel_pt_count", PT_COUNT, 0);
      chk("rel_buf_full", BUF_FULL, 1'b0);
      chk_box("rel");
   endtask

   initial begin
      RST         = 1'b1;
      IN_VALID    = 1'b0;
      IN_X        = '0;
      IN_Y        = '0;
      RD_GRP      = 4'd15;
      SOLVER_DONE = 1'b0;
      step();
      step();
      chk("rst_in_ready", IN_READY, 1'b0);
      chk("rst_pt_count", PT_COUNT, 0);
      chk("rst_load_done", LOAD_DONE, 1'b0);
      chk("rst_buf_full", BUF_FULL, 1'b0);
      chk("rst_rd_x", RD_X, 16'h0);
      chk("rst_rd_y", RD_Y, 16'h0);
      chk_box("rst");
      RST = 1'b0;
      #1;
      chk("post_rst_in_ready", IN_READY, 1'b1);

      ld_cnt = 0;
      fill(NPTS, 0, 0);
      check_full();
      sweep();
      hold_test();
      release_frame();

      ld_cnt = 0;
      fill(NPTS, 1, 1);
      check_full();
      chk("alt_min_x", MIN_X, 4'd3);
      chk("alt_max_y", MAX_Y, 4'd14);
      sweep();
      release_frame();

      ld_cnt = 0;
      fill(17, 2, 2);
      chk("part_pt_count", PT_COUNT, 17);
      IN_VALID = 1'b1;
      RST      = 1'b1;
      #1;
      chk("rst_mid_in_ready", IN_READY, 1'b0);
      step();
      RST      = 1'b0;
      IN_VALID = 1'b0;
      mdl_cnt  = 0;
      chk("rst_mid_pt_count", PT_COUNT, 0);
      chk_box("rst_mid");
      #1;
      chk("rst_mid_ready", IN_READY, 1'b1);
      step();
      step();
      chk("rst_mid_no_done", ld_cnt, 0);

      ld_cnt = 0;
      fill(NPTS, 2, 2);
      check_full();
      sweep();
      release_frame();

      ld_cnt = 0;
      fill(NPTS, 3, 0);
      check_full();
      release_frame();

      ld_cnt = 0;
      fill(NPTS, 4, 2);
      check_full();
      chk("inv_min_x", MIN_X, 4'd0);
      chk("inv_min_y", MIN_Y, 4'd15);
      sweep();
      release_frame();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout, expected finish");
      $fatal(1, "bench timeout");
   end

endmodule
